// File: rtl/switch_egress_port.sv
// Egress side of one switch output port: buffers 4-word cells, applies backpressure,
// strips the frame header and serialises the payload as a byte stream.
module switch_egress_port #(
    parameter int DEPTH     = 256,
    parameter int BP_MARGIN = 8,
    parameter int MAX_LEN   = 1518
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         cell_wr,
    input  logic [127:0] cell_din,
    input  logic         cell_first,
    input  logic         cell_last,
    output logic         cell_bp,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    output logic         tx_sof,
    output logic         tx_eof,
    input  logic         tx_ready,
    output logic [15:0]  frame_cnt,
    output logic [15:0]  err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] BPM_C   = CW'(BP_MARGIN);
    localparam logic [11:0]   MAX_C   = 12'(MAX_LEN);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_DRAIN} state_t;

    // Entry layout: [129]=sof tag, [128]=eof tag, [127:0]=cell word
    logic [129:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [1:0]    wcnt_q;
    logic          cell_bp_q;
    state_t        state_q, state_d;
    logic [11:0]   rem_q, rem_d;
    logic [3:0]    bidx_q, bidx_d;
    logic          first_q, first_d;
    logic [15:0]   frame_cnt_q, err_cnt_q;

    logic          empty, full, push, pop;
    logic          fsm_err, frame_inc;
    logic [129:0]  head;
    logic          head_sof, head_eof;
    logic [11:0]   head_len;
    logic          len_ok, last_byte, word_end;
    logic [7:0]    head_bytes [16];
    logic [129:0]  entry_in;
    logic [1:0]    err_add;
    logic [16:0]   err_sum;

    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_C);
    assign push     = cell_wr && !full;
    assign entry_in = {cell_first && (wcnt_q == 2'd0), cell_last && (wcnt_q == 2'd3), cell_din};

    // First-word-fall-through: the head entry is read combinationally
    assign head     = mem[rd_ptr_q];
    assign head_sof = head[129];
    assign head_eof = head[128];
    assign head_len = head[11:0];

    for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
        assign head_bytes[gi] = head[127-8*gi -: 8];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= entry_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wcnt_q    <= '0;
            cell_bp_q <= 1'b0;
        end else begin
            if (cell_wr) wcnt_q <= wcnt_q + 2'd1;
            if (push)    wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            cell_bp_q <= (DEPTH_C - count_q) < BPM_C;
        end
    end

    assign len_ok    = (head_len != 12'd0) && (head_len <= MAX_C);
    assign last_byte = (rem_q == 12'd1);
    assign word_end  = (bidx_q == 4'd15);

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        bidx_d    = bidx_q;
        first_d   = first_q;
        pop       = 1'b0;
        fsm_err   = 1'b0;
        frame_inc = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'd0;
        tx_sof    = 1'b0;
        tx_eof    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head_sof) begin
                        rem_d  = head_len;
                        bidx_d = 4'd0;
                        if (len_ok) begin
                            state_d = S_DATA;
                            first_d = 1'b1;
                        end else begin
                            fsm_err = 1'b1;
                            state_d = head_eof ? S_IDLE : S_DRAIN;
                        end
                    end else begin
                        fsm_err = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (!empty) begin
                    tx_valid = 1'b1;
                    tx_data  = head_bytes[bidx_q];
                    tx_sof   = first_q;
                    tx_eof   = last_byte || (head_eof && word_end);
                    if (tx_ready) begin
                        rem_d   = rem_q - 12'd1;
                        bidx_d  = bidx_q + 4'd1;
                        first_d = 1'b0;
                        if (last_byte) begin
                            pop       = 1'b1;
                            frame_inc = 1'b1;
                            state_d   = head_eof ? S_IDLE : S_DRAIN;
                        end else if (head_eof && word_end) begin
                            // Frame ended before its declared length
                            pop       = 1'b1;
                            fsm_err   = 1'b1;
                            frame_inc = 1'b1;
                            state_d   = S_IDLE;
                        end else if (word_end) begin
                            pop = 1'b1;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head_eof) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign err_add = {1'b0, cell_wr && full} + {1'b0, fsm_err};
    assign err_sum = {1'b0, err_cnt_q} + {15'd0, err_add};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            bidx_q      <= '0;
            first_q     <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            bidx_q  <= bidx_d;
            first_q <= first_d;
            if (frame_inc && (frame_cnt_q != 16'hFFFF)) frame_cnt_q <= frame_cnt_q + 16'd1;
            err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    assign cell_bp   = cell_bp_q;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule
